// File: rtl/bcd_countdown_timer.sv
// bcd_countdown_timer
//   Two-digit BCD countdown for a game round. It loads a preset (tens/ones),
//   counts down once per one_sec_in tick while running, and stops at 00.
//   On reaching 00 it raises a level flag and emits a single-cycle pulse.
//
// State table:
//   state     | meaning
//   S_IDLE    | preset loaded, waiting for start
//   S_RUNNING | counting down on each unheld tick
//   S_EXPIRED | reached 00; only load or reset leaves
//
// Ports:
//   clk           in   system clock
//   reset         in   asynchronous active-low reset
//   one_sec_in    in   one-cycle tick, once per second
//   load          in   pulse: restore preset, go to IDLE (highest priority)
//   start         in   pulse: begin counting from IDLE
//   hold          in   level: discard ticks while RUNNING
//   tens_out      out  current tens BCD digit
//   ones_out      out  current ones BCD digit
//   running       out  high in RUNNING
//   time_up       out  high in EXPIRED
//   time_up_pulse out  one-cycle pulse on the edge that enters EXPIRED
module bcd_countdown_timer #(
  parameter int START_TENS = 3,
  parameter int START_ONES = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       one_sec_in,
  input  logic       load,
  input  logic       start,
  input  logic       hold,
  output logic [3:0] tens_out,
  output logic [3:0] ones_out,
  output logic       running,
  output logic       time_up,
  output logic       time_up_pulse
);

  localparam logic [3:0] P_TENS = 4'(START_TENS);
  localparam logic [3:0] P_ONES = 4'(START_ONES);
  localparam logic       P_ZERO = (START_TENS == 0) && (START_ONES == 0);

  // A preset above 9 would put non-BCD codes on the digit decoders.
  if (START_TENS > 9 || START_ONES > 9 || START_TENS < 0 || START_ONES < 0) begin : g_bad_preset
    $error("bcd_countdown_timer: preset digits must be 0-9");
  end

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RUNNING = 2'd1,
    S_EXPIRED = 2'd2
  } state_t;

  state_t     r_state, w_state_nxt;
  logic [3:0] r_tens, w_tens_nxt;
  logic [3:0] r_ones, w_ones_nxt;
  logic       r_pulse, w_pulse_nxt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_tens  <= P_TENS;
      r_ones  <= P_ONES;
      r_pulse <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_tens  <= w_tens_nxt;
      r_ones  <= w_ones_nxt;
      r_pulse <= w_pulse_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_tens_nxt  = r_tens;
    w_ones_nxt  = r_ones;
    w_pulse_nxt = 1'b0;

    if (load) begin
      w_state_nxt = S_IDLE;
      w_tens_nxt  = P_TENS;
      w_ones_nxt  = P_ONES;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            if (P_ZERO) begin
              w_state_nxt = S_EXPIRED;
              w_pulse_nxt = 1'b1;
            end else begin
              w_state_nxt = S_RUNNING;
            end
          end
        end

        S_RUNNING: begin
          if (one_sec_in && !hold) begin
            if (r_ones != 4'd0) begin
              w_ones_nxt = r_ones - 4'd1;
            end else if (r_tens != 4'd0) begin
              w_ones_nxt = 4'd9;
              w_tens_nxt = r_tens - 4'd1;
            end
            // Also catches a stray 00 in RUNNING so the count can never wrap.
            if (w_tens_nxt == 4'd0 && w_ones_nxt == 4'd0) begin
              w_state_nxt = S_EXPIRED;
              w_pulse_nxt = 1'b1;
            end
          end
        end

        S_EXPIRED: begin
          w_tens_nxt = 4'd0;
          w_ones_nxt = 4'd0;
        end

        default: begin
          w_state_nxt = S_IDLE;
          w_tens_nxt  = P_TENS;
          w_ones_nxt  = P_ONES;
        end
      endcase
    end
  end

  assign tens_out      = r_tens;
  assign ones_out      = r_ones;
  assign running       = (r_state == S_RUNNING);
  assign time_up       = (r_state == S_EXPIRED);
  assign time_up_pulse = r_pulse;

endmodule

// File: tb/tb_bcd_countdown_timer.sv
module tb_bcd_countdown_timer;

  logic       clk;
  logic       rst_n;
  logic       tick, ld, st, hd;
  logic [3:0] tens, ones;
  logic       run, tup, tpulse;

  logic       tick0, ld0, st0, hd0;
  logic [3:0] tens0, ones0;
  logic       run0, tup0, tpulse0;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 0;

  // Model: remaining seconds as a plain integer plus a mode.
  localparam int PRESET = 30;
  localparam int M_IDLE = 0, M_RUN = 1, M_EXP = 2;
  int m_count;
  int m_mode;
  bit m_pulse;

  bcd_countdown_timer dut (
    .clk(clk), .reset(rst_n), .one_sec_in(tick), .load(ld), .start(st), .hold(hd),
    .tens_out(tens), .ones_out(ones), .running(run), .time_up(tup), .time_up_pulse(tpulse)
  );

  bcd_countdown_timer #(.START_TENS(0), .START_ONES(0)) dut0 (
    .clk(clk), .reset(rst_n), .one_sec_in(tick0), .load(ld0), .start(st0), .hold(hd0),
    .tens_out(tens0), .ones_out(ones0), .running(run0), .time_up(tup0), .time_up_pulse(tpulse0)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_count = PRESET;
    m_mode  = M_IDLE;
    m_pulse = 0;
  endtask

  // Drive one cycle of inputs, let the edge happen, advance the model.
  task automatic step(input bit l, input bit s, input bit t, input bit h);
    ld = l; st = s; tick = t; hd = h;
    @(posedge clk);
    m_pulse = 0;
    if (l) begin
      m_count = PRESET;
      m_mode  = M_IDLE;
    end else if (m_mode == M_IDLE && s) begin
      if (PRESET == 0) begin m_mode = M_EXP; m_pulse = 1; end
      else m_mode = M_RUN;
    end else if (m_mode == M_RUN && t && !h) begin
      m_count = m_count - 1;
      if (m_count == 0) begin m_mode = M_EXP; m_pulse = 1; end
    end
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 1, 0);
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en && rst_n) begin
      chk("cyc_tens",  int'(tens),   m_count / 10);
      chk("cyc_ones",  int'(ones),   m_count % 10);
      chk("cyc_run",   int'(run),    int'(m_mode == M_RUN));
      chk("cyc_tup",   int'(tup),    int'(m_mode == M_EXP));
      chk("cyc_pulse", int'(tpulse), int'(m_pulse));
    end
  end

  initial begin
    rst_n = 1; tick = 0; ld = 0; st = 0; hd = 0;
    tick0 = 0; ld0 = 0; st0 = 0; hd0 = 0;
    model_reset();

    // Asynchronous reset mid-cycle, checked before any clock edge.
    #2 rst_n = 0;
    #1;
    chk("rst_tens", int'(tens), 3);
    chk("rst_ones", int'(ones), 0);
    chk("rst_run",  int'(run),  0);
    chk("rst_tup",  int'(tup),  0);
    chk("rst_pulse", int'(tpulse), 0);
    #10 rst_n = 1;             // released at t=13, between edges
    chk_en = 1;

    // Preset 00 instance: start goes straight to EXPIRED with one pulse.
    chk("p0_idle_run", int'(run0), 0);
    st0 = 1;
    step(0, 0, 0, 0);
    st0 = 0;
    chk("p0_tup",   int'(tup0),   1);
    chk("p0_pulse", int'(tpulse0), 1);
    chk("p0_digits", int'({tens0, ones0}), 0);
    step(0, 0, 0, 0);
    chk("p0_pulse_drop", int'(tpulse0), 0);
    chk("p0_tup_hold",   int'(tup0),    1);

    // Count down with borrow, run to expiry, extra ticks.
    step(0, 1, 0, 0);
    chk("start_run", int'(run), 1);
    ticks(1);
    chk("t1", int'({tens, ones}), 8'h29);
    ticks(9);
    chk("t10", int'({tens, ones}), 8'h20);
    ticks(1);
    chk("t11_borrow", int'({tens, ones}), 8'h19);
    ticks(19);
    chk("t30_digits", int'({tens, ones}), 8'h00);
    chk("t30_tup",    int'(tup), 1);
    chk("t30_pulse",  int'(tpulse), 1);
    ticks(1);
    chk("t31_pulse",  int'(tpulse), 0);
    ticks(4);
    chk("t35_digits", int'({tens, ones}), 8'h00);
    step(0, 1, 0, 1);          // start and hold ignored in EXPIRED
    chk("exp_start_ign", int'(tup), 1);

    // Hold discards ticks, no catch-up.
    step(1, 0, 0, 0);
    chk("load_idle", int'({tens, ones}), 8'h30);
    step(0, 1, 0, 0);
    ticks(5);
    chk("run25", int'({tens, ones}), 8'h25);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 1, 1);
      step(0, 0, 0, 1);
    end
    chk("hold25", int'({tens, ones}), 8'h25);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    ticks(1);
    chk("after_hold24", int'({tens, ones}), 8'h24);

    // Load beats a coincident tick; idle ignores ticks.
    ticks(7);
    chk("run17", int'({tens, ones}), 8'h17);
    step(1, 0, 1, 0);
    chk("load_tick", int'({tens, ones}), 8'h30);
    chk("load_run",  int'(run), 0);
    ticks(3);
    chk("idle_ticks", int'({tens, ones}), 8'h30);
    step(0, 0, 0, 1);          // hold in IDLE is harmless

    // Start with coincident tick: running, digits unchanged.
    step(0, 1, 1, 0);
    chk("start_tick_run", int'(run), 1);
    chk("start_tick_dig", int'({tens, ones}), 8'h30);
    step(0, 1, 1, 0);          // start ignored while running, tick counts
    chk("run_start_ign", int'({tens, ones}), 8'h29);
    ticks(29);
    chk("exp2_tup", int'(tup), 1);

    // Reset while EXPIRED.
    #2 rst_n = 0;
    chk_en = 0;
    #1;
    chk("rst_exp_dig", int'({tens, ones}), 8'h30);
    chk("rst_exp_tup", int'(tup), 0);
    chk("rst_exp_run", int'(run), 0);
    model_reset();
    @(negedge clk);
    #2 rst_n = 1;
    chk_en = 1;
    ticks(2);
    chk("rst_no_restart", int'({tens, ones}), 8'h30);
    step(0, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
